// File: rtl/adder_subtractor_64bit_pkg.sv
// Shared constants for the 64-bit adder/subtractor.
// Width and operation-select encodings.
package adder_subtractor_64bit_pkg;
  localparam int   ADDSUB_W = 64;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;
endpackage

// File: rtl/adder_subtractor_64bit_full_adder.sv
// One-bit full-adder cell for the ripple-carry chain.
// Ports: a, b, cin in; s (sum), cout (carry) out.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic w_p;

  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);
endmodule

// File: rtl/adder_subtractor_64bit.sv
// 64-bit ripple-carry add/sub with registered result and flags.
// Ports: clk, rst (sync, high), A, B, S (1=sub) in; Out, Cout, Ovf, Zero out.
module adder_subtractor_64bit
  import adder_subtractor_64bit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDSUB_W-1:0] A,
  input  logic [ADDSUB_W-1:0] B,
  input  logic                S,
  output logic [ADDSUB_W-1:0] Out,
  output logic                Cout,
  output logic                Ovf,
  output logic                Zero
);
  logic                w_sub;
  logic [ADDSUB_W-1:0] w_bx;
  logic [ADDSUB_W-1:0] w_sum;
  logic [ADDSUB_W:0]   w_c;

  logic [ADDSUB_W-1:0] r_out;
  logic                r_cout;
  logic                r_ovf;
  logic                r_zero;

  // Subtract is A + ~B + 1: invert B and inject the +1 as carry-in.
  assign w_sub  = (S == OP_SUB);
  assign w_bx   = B ^ {ADDSUB_W{w_sub}};
  assign w_c[0] = w_sub;

  for (genvar i = 0; i < ADDSUB_W; i++) begin : g_fa
    full_adder u_fa (
      .a    (A[i]),
      .b    (w_bx[i]),
      .cin  (w_c[i]),
      .s    (w_sum[i]),
      .cout (w_c[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      r_out  <= w_sum;
      r_cout <= w_c[ADDSUB_W];
      // Signed overflow: carry into sign bit differs from carry out.
      r_ovf  <= w_c[ADDSUB_W] ^ w_c[ADDSUB_W-1];
      r_zero <= (w_sum == '0);
    end
  end

  assign Out  = r_out;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;
  assign Zero = r_zero;
endmodule

// File: tb/tb_adder_subtractor_64bit.sv
// Directed self-checking bench for adder_subtractor_64bit.
// Hand-computed vectors; one assertion per vector on {Out,Cout,Ovf,Zero}.
module tb_adder_subtractor_64bit;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] A, B;
  logic        S;
  logic [63:0] Out;
  logic        Cout, Ovf, Zero;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  adder_subtractor_64bit dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .S    (S),
    .Out  (Out),
    .Cout (Cout),
    .Ovf  (Ovf),
    .Zero (Zero)
  );

  task automatic chk(input string tag, input logic [63:0] eo,
                     input logic ec, input logic ev, input logic ez);
    logic [66:0] obs, exp;
    obs = {Out, Cout, Ovf, Zero};
    exp = {eo, ec, ev, ez};
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got Out=%h C=%b V=%b Z=%b, want Out=%h C=%b V=%b Z=%b",
             tag, Out, Cout, Ovf, Zero, eo, ec, ev, ez);
    end
  endtask

  task automatic step(input logic [63:0] a, input logic [63:0] b,
                      input logic s);
    @(negedge clk);
    A = a; B = b; S = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; S = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 64'h0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst = 1'b0;

    step(64'd100, 64'd100, 1'b0);
    chk("add_100_100", 64'd200, 1'b0, 1'b0, 1'b0);

    step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    chk("wrap", 64'h0, 1'b1, 1'b0, 1'b1);

    step(64'd1024, 64'd512, 1'b1);
    chk("sub_1024_512", 64'd512, 1'b1, 1'b0, 1'b0);

    step(64'd0, 64'd0, 1'b1);
    chk("sub_0_0", 64'h0, 1'b1, 1'b0, 1'b1);

    step(64'd0, 64'd1, 1'b1);
    chk("borrow", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

    step(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    chk("pos_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // Operands changing mid-cycle must not reach the outputs.
    @(negedge clk);
    A = 64'd3; B = 64'd4; S = 1'b0;
    #2;
    chk("hold_between_edges", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    // Reset with live operands discards the result.
    @(negedge clk);
    A = 64'd5; B = 64'd3; S = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_mid", 64'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after_reset", 64'd8, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations, a new one every cycle.
    step(64'd10, 64'd20, 1'b0);
    chk("b2b_add", 64'd30, 1'b0, 1'b0, 1'b0);
    step(64'd30, 64'd10, 1'b1);
    chk("b2b_sub", 64'd20, 1'b1, 1'b0, 1'b0);
    step(64'h8000_0000_0000_0000, 64'd1, 1'b1);
    chk("neg_ovf_sub", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("m1_plus_m1", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
    step(64'd5, 64'd7, 1'b1);
    chk("sub_5_7", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    step(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    chk("min_plus_min", 64'h0, 1'b1, 1'b1, 1'b1);
    step(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0);
    chk("mixed_add", 64'h1234_5678_9ABC_DF00, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
